// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control FSM and ALUControl.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ST_W    = 4;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        RTYPE_WB = 4'd8,
        BEQ      = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        JUMP     = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'b10;

    // Datapath control word decoded from the current state.
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_src;
        logic               pc_write;
        logic               pc_write_cond;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multicycle controller and its datapath.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       Opcode;
    logic             Zero;
    logic             MemReady;
    logic [1:0]       ALUop;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSrc;
    logic             PCEn;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             IllegalOp;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Opcode, Zero, MemReady,
        output ALUop, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, IllegalOp, State, InstrCount
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  ALUop, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, IllegalOp, State, InstrCount
    );
endinterface

// File: rtl/mc_outdec.sv
// Moore strobe decoder: state to datapath controls; fetch writes wait on memory.
module mc_outdec
    import mc_pkg::*;
(
    input  state_e state,
    input  logic   mem_rdy,
    output ctrl_t  ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        unique case (state)
            FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.ir_write  = mem_rdy;
                ctrl_c.pc_write  = mem_rdy;
            end
            DECODE:   ctrl_c.alu_src_b = 2'b11;
            MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
            end
            RTYPE_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_FUNC;
            end
            RTYPE_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            BEQ: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_op        = ALUOP_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_src        = 2'b01;
            end
            ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
            end
            ADDI_WB:  ctrl_c.reg_write = 1'b1;
            JUMP: begin
                ctrl_c.pc_write = 1'b1;
                ctrl_c.pc_src   = 2'b10;
            end
            default:  ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: sequences each instruction and counts retirements.
module multicycle_control
    import mc_pkg::*;
#(
    parameter bit          WAIT_ON_MEM = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_c;
    logic              retire_c;
    logic              illegal_c;
    ctrl_t             ctrl_c;

    assign rdy_c = WAIT_ON_MEM ? bus.MemReady : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state; opcode is only looked at in DECODE, then held for lw/sw steering.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        retire_c  = 1'b0;
        illegal_c = 1'b0;
        unique case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (rdy_c) state_d = DECODE;
            DECODE: begin
                opcode_d = bus.Opcode;
                unique case (bus.Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPE_EX;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (opcode_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    if (rdy_c) state_d = MEMWB;
            MEMWB: begin
                state_d  = FETCH;
                retire_c = 1'b1;
            end
            MEMWR: begin
                if (rdy_c) begin
                    state_d  = FETCH;
                    retire_c = 1'b1;
                end
            end
            RTYPE_EX: state_d = RTYPE_WB;
            ADDI_EX:  state_d = ADDI_WB;
            RTYPE_WB, BEQ, ADDI_WB, JUMP: begin
                state_d  = FETCH;
                retire_c = 1'b1;
            end
            default:  state_d = FETCH;
        endcase
        cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
    end

    mc_outdec u_outdec (
        .state   (state_q),
        .mem_rdy (rdy_c),
        .ctrl_c  (ctrl_c)
    );

    assign bus.ALUop      = ctrl_c.alu_op;
    assign bus.ALUSrcA    = ctrl_c.alu_src_a;
    assign bus.ALUSrcB    = ctrl_c.alu_src_b;
    assign bus.PCSrc      = ctrl_c.pc_src;
    assign bus.PCEn       = ctrl_c.pc_write | (ctrl_c.pc_write_cond & bus.Zero);
    assign bus.IorD       = ctrl_c.iord;
    assign bus.MemRead    = ctrl_c.mem_read;
    assign bus.MemWrite   = ctrl_c.mem_write;
    assign bus.IRWrite    = ctrl_c.ir_write;
    assign bus.RegDst     = ctrl_c.reg_dst;
    assign bus.MemtoReg   = ctrl_c.mem_to_reg;
    assign bus.RegWrite   = ctrl_c.reg_write;
    assign bus.IllegalOp  = illegal_c;
    assign bus.State      = state_q;
    assign bus.InstrCount = cnt_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath. Decodes the 6-bit opcode over several cycles, drives datapath strobes and ALUop[1:0].
- ALUop feeds ALUControl, which combines it with FuncCode to form ALUctl. This block sits directly upstream of ALUControl.
- Waits on a memory-ready handshake and counts retired instructions.

Parameters:
- WAIT_ON_MEM, 1, 1: memory states hold until MemReady=1. 0: MemReady is treated as constant 1.
- CNT_W, 32, width of the InstrCount retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction[31:26]; sampled only in DECODE
- Zero  in  1  ALU zero flag, used for beq
- MemReady  in  1  memory completes the access this cycle
- ALUop  out  2  00 add, 01 sub, 10 use FuncCode; 11 is never driven
- ALUSrcA  out  1  0 selects PC, 1 selects register A
- ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- PCEn  out  1  PCWrite | (PCWriteCond & Zero)
- IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite  out  1 each  datapath strobes
- IllegalOp  out  1  one-cycle pulse on an unknown opcode
- State  out  4  current state, for debug
- InstrCount  out  CNT_W  number of retired instructions

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE, InstrCount=0.
  - All strobes 0, ALUop=00, selects 00.
  - Reset mid-instruction aborts immediately with no partial writes.
- IDLE: all outputs 0. Goes to FETCH on the first clock after reset release.
- Outputs are Moore-decoded from State, except the memory-completion strobes, which are additionally gated by MemReady (marked *).
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSrc=00.
  - Asserts IRWrite* and PCWrite* only when MemReady=1, then goes to DECODE.
  - Holds while MemReady=0, with IRWrite=0 and PCEn=0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by Opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100 -> BEQ
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - any other value -> FETCH, with IllegalOp=1 for this cycle and InstrCount unchanged
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEMRD for lw, MEMWR for sw (opcode latched in DECODE).
- MEMRD: MemRead=1, IorD=1. On MemReady goes to MEMWB; otherwise holds.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, then FETCH. Retires.
- MEMWR: MemWrite=1, IorD=1. On MemReady goes to FETCH and retires; otherwise holds with MemWrite still 1.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUop=10, then RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH. Retires.
- BEQ:
  - ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSrc=01, so PCEn=Zero.
  - Goes to FETCH. Retires regardless of Zero.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUop=00, then ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH. Retires.
- JUMP: PCWrite=1, PCSrc=10, then FETCH. Retires.
- Retire: InstrCount increments by 1 on the clock edge that leaves a retiring state. It wraps modulo 2^CNT_W with no saturation.
- Latency in cycles (MemReady tied high): R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Unused state encodings go to FETCH on the next clock; no strobes are asserted in them.
- Opcode changing outside DECODE has no effect.

Decomposition:
- Shared package mc_pkg holds:
  - state enum: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, BEQ=9, ADDI_EX=10, ADDI_WB=11, JUMP=12
  - opcode constants
  - ALUop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC), shared with ALUControl
- One natural sub-module, mc_outdec: combinational decoder from state plus MemReady to the strobes.
- The FSM and InstrCount counter stay in the top.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 asserted mid-MEMRD.
   - Response: State=0 and all strobes 0 immediately, InstrCount=0. After release: IDLE, then FETCH, with MemRead=1.
2. R-type:
   - Stimulus: MemReady=1, Opcode=000000.
   - Response: states 1,2,7,8,1. ALUop=10 in RTYPE_EX. RegWrite=1 with RegDst=1 in RTYPE_WB. InstrCount goes 0 to 1 after 4 cycles.
3. lw with memory wait:
   - Stimulus: Opcode=100011, MemReady held 0 for 3 cycles in MEMRD.
   - Response: MEMRD held 4 cycles total. MEMWB has MemtoReg=1. Latency 8 cycles. IRWrite pulses exactly once.
4. beq:
   - Stimulus: Opcode=000100, once with Zero=1 and once with Zero=0.
   - Response: ALUop=01 in both. PCEn=1 vs 0 in BEQ. Both retire.
5. Illegal opcode:
   - Stimulus: Opcode=111111.
   - Response: IllegalOp=1 for exactly 1 cycle in DECODE, next state FETCH, InstrCount unchanged.
6. Counter wrap:
   - Stimulus: CNT_W=4, run 16 j instructions.
   - Response: InstrCount goes 15 then 0, with JUMP driving PCSrc=10 and PCEn=1 each time.
